// File: rtl/spart_echo_ctrl.sv
// SPART bus master: programs the baud divisor, then echoes every received byte back out.
// Latency: a received byte can leave on the second cycle after its RD cycle at the earliest (RD, IDLE, WR).
// Backpressure: a full FIFO blocks RD so the byte waits in the SPART; an empty FIFO or a low tbr blocks WR.
module spart_echo_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         br_cfg,
  input  logic               rda,
  input  logic               tbr,
  output logic               iocs,
  output logic               iorw,
  output logic [1:0]         ioaddr,
  inout  wire  [7:0]         databus,
  output logic               cfg_done,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               fifo_full
);

  // Bus register addresses inside the SPART
  localparam logic [1:0] ADDR_BUF   = 2'b00;
  localparam logic [1:0] ADDR_DB_LO = 2'b10;
  localparam logic [1:0] ADDR_DB_HI = 2'b11;

  localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_CFG_LO = 3'd1,
    S_CFG_HI = 3'd2,
    S_IDLE   = 3'd3,
    S_RD     = 3'd4,
    S_WR     = 3'd5
  } state_t;

  state_t               state;
  state_t               state_nxt;

  // Baud select captured at the start of each (re)configuration
  logic [1:0]           cfg_q;
  // Remembers which side won the last transaction, for round-robin arbitration
  logic                 last_rd;

  // Echo FIFO storage and pointers
  logic [7:0]           mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;

  logic [15:0]          div;
  logic [7:0]           dout;
  logic                 drive;
  logic                 rd_ok;
  logic                 wr_ok;
  logic                 cfg_chg;

  // Divisor lookup for the latched baud select
  always_comb begin
    div = 16'h0145;
    case (cfg_q)
      2'b00:   div = 16'h0145;
      2'b01:   div = 16'h00A2;
      2'b10:   div = 16'h0051;
      2'b11:   div = 16'h0028;
      default: div = 16'h0145;
    endcase
  end

  assign fifo_full = (fifo_count == COUNT_FULL);
  assign rd_ok     = rda && !fifo_full;
  assign wr_ok     = tbr && (fifo_count != '0);
  assign cfg_chg   = (br_cfg != cfg_q);

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: config sequence, then arbitration from IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:   state_nxt = S_CFG_LO;
      S_CFG_LO: state_nxt = S_CFG_HI;
      S_CFG_HI: state_nxt = S_IDLE;
      S_IDLE: begin
        if (cfg_chg) begin
          state_nxt = S_INIT;
        end else if (rd_ok && wr_ok) begin
          state_nxt = last_rd ? S_WR : S_RD;
        end else if (rd_ok) begin
          state_nxt = S_RD;
        end else if (wr_ok) begin
          state_nxt = S_WR;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      // Every bus transaction is one cycle and always drops back to IDLE,
      // giving the SPART a cycle to update rda/tbr before the next one.
      S_RD:     state_nxt = S_IDLE;
      S_WR:     state_nxt = S_IDLE;
      default:  state_nxt = S_INIT;
    endcase
  end

  // Moore output decode from the state register only
  always_comb begin
    iocs     = 1'b0;
    iorw     = 1'b1;
    ioaddr   = ADDR_BUF;
    dout     = 8'h00;
    drive    = 1'b0;
    cfg_done = 1'b0;
    case (state)
      S_CFG_LO: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = ADDR_DB_LO;
        dout   = div[7:0];
        drive  = 1'b1;
      end
      S_CFG_HI: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = ADDR_DB_HI;
        dout   = div[15:8];
        drive  = 1'b1;
      end
      S_IDLE: begin
        cfg_done = 1'b1;
      end
      S_RD: begin
        iocs     = 1'b1;
        cfg_done = 1'b1;
      end
      S_WR: begin
        iocs     = 1'b1;
        iorw     = 1'b0;
        dout     = mem[rd_ptr];
        drive    = 1'b1;
        cfg_done = 1'b1;
      end
      default: begin
        iocs = 1'b0;
      end
    endcase
  end

  // The bus is only ours while writing; otherwise the SPART may drive it
  assign databus = drive ? dout : 8'hzz;

  // Latch the baud select when a (re)configuration starts
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= 2'b00;
    end else if (state == S_INIT) begin
      cfg_q <= br_cfg;
    end
  end

  // FIFO pointers, occupancy and arbitration memory; push and pop are exclusive
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_rd    <= 1'b0;
    end else if (state == S_RD) begin
      wr_ptr     <= wr_ptr + FIFO_AW'(1);
      fifo_count <= fifo_count + (FIFO_AW+1)'(1);
      last_rd    <= 1'b1;
    end else if (state == S_WR) begin
      rd_ptr     <= rd_ptr + FIFO_AW'(1);
      fifo_count <= fifo_count - (FIFO_AW+1)'(1);
      last_rd    <= 1'b0;
    end
  end

  // Capture the received byte at the closing edge of an RD cycle
  always_ff @(posedge clk) begin
    if (!rst && state == S_RD) begin
      mem[wr_ptr] <= databus;
    end
  end

endmodule
